route_cntrl: RTL

ROUTE_CNTRL -- requirements
Module: route_cntrl

---
 rtl/route_pkg.sv | 29 ++
 rtl/route_fifo.sv | 75 +++++++
 rtl/route_cntrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/route_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : route_pkg
//  Description : Shared types and constants for the route controller:
//                FSM state encoding, command opcodes, default ID width.
//  Revision    : 1.0 - initial release
// ============================================================================
package route_pkg;

    // Default station / destination ID width
    localparam int ID_W_DEF = 6;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MOVE  = 2'd1,
        ST_DWELL = 2'd2
    } state_e;

    // Command opcodes carried in the top two bits of cmd
    typedef enum logic [1:0] {
        OP_STOP   = 2'b00,
        OP_GO     = 2'b01,
        OP_APPEND = 2'b10,
        OP_RSVD   = 2'b11
    } opcode_e;

endpackage
`default_nettype wire

// File: rtl/route_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : route_fifo
//  Description : DEPTH x W destination queue with push, pop and flush.
//                Flush wins over pop; a push in the flush cycle becomes the
//                sole entry. Push is accepted while full if a pop happens in
//                the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module route_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [W-1:0]             din_i,
    output logic [W-1:0]             head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;

    logic w_do_pop;
    logic w_do_push;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CW'(DEPTH));
    assign count_o   = count_q;
    assign head_o    = mem_q[rd_ptr_q];
    assign w_do_pop  = pop_i & ~empty_o;
    assign w_do_push = push_i & (~full_o | w_do_pop);

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= push_i ? AW'(1) : '0;
            count_q  <= push_i ? CW'(1) : '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage write; a flushing push always lands in slot 0
    always_ff @(posedge clk) begin
        if (flush_i) begin
            if (push_i) mem_q[0] <= din_i;
        end else if (w_do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/route_cntrl.sv
`default_nettype none
// ============================================================================
//  Module      : route_cntrl
//  Description : Route controller. Queues destinations from commands, drives
//                go/in_transit, pops the queue on matching barcode stations,
//                pulses arrived at the final stop and buzzes when blocked.
//                Optional dwell at intermediate stations: ROUTE_DWELL_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module route_cntrl
    import route_pkg::*;
#(
    parameter int ID_W      = ID_W_DEF,
    parameter int DEPTH     = 4,
    parameter int BUZZ_HALF = 6250,
    parameter int DWELL_CYC = 1000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ID_W+1:0]          cmd,
    input  logic                     cmd_rdy,
    output logic                     clr_cmd_rdy,
    input  logic [ID_W+1:0]          ID,
    input  logic                     ID_vld,
    output logic                     clr_ID_vld,
    input  logic                     OK2Move,
    output logic                     go,
    output logic                     in_transit,
    output logic                     buzz,
    output logic                     buzz_n,
    output logic                     arrived,
    output logic                     cmd_err,
    output logic [$clog2(DEPTH):0]   q_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int BW = $clog2(BUZZ_HALF + 1);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_MOVE  = ST_MOVE;
`ifdef ROUTE_DWELL_EN
    localparam logic [1:0] S_DWELL = ST_DWELL;
    localparam int         DW      = $clog2(DWELL_CYC + 1);
`endif

    logic [1:0]      state_q, state_d;
    logic            in_transit_q;
    logic            arrived_q, arrived_d;
    logic            cmd_err_q, cmd_err_d;
    logic            buzz_q;
    logic [BW-1:0]   buzz_cnt_q;

    logic [1:0]      w_op;
    logic [ID_W-1:0] w_dest;
    logic            w_match;
    logic            w_push, w_pop, w_flush;
    logic [ID_W-1:0] w_head;
    logic [CW-1:0]   w_count;
    logic            w_full, w_empty;
    logic            w_buzz_cond;

    // Handshake consumes are pure wires so they also act during reset
    assign clr_cmd_rdy = cmd_rdy;
    assign clr_ID_vld  = ID_vld;

    assign w_op   = cmd[ID_W+1:ID_W];
    assign w_dest = cmd[ID_W-1:0];

    // Only a well-formed station ID equal to the queue head counts, in MOVE
    assign w_match = ID_vld && (ID[ID_W+1:ID_W] == 2'b00) &&
                     (ID[ID_W-1:0] == w_head) && (state_q == S_MOVE) && !w_empty;

    route_fifo #(
        .DEPTH (DEPTH),
        .W     (ID_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .flush_i (w_flush),
        .din_i   (w_dest),
        .head_o  (w_head),
        .count_o (w_count),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

`ifdef ROUTE_DWELL_EN
    logic [DW-1:0] dwell_cnt_q;

    // Dwell timer runs only while parked at an intermediate station
    always_ff @(posedge clk) begin
        if (!rst_n || state_q != S_DWELL) dwell_cnt_q <= '0;
        else                              dwell_cnt_q <= dwell_cnt_q + DW'(1);
    end
`else
    logic unused_dwell_cyc;
    assign unused_dwell_cyc = ^DWELL_CYC;
`endif

    // Command decode, queue control and next-state selection
    always_comb begin
        state_d   = state_q;
        w_push    = 1'b0;
        w_pop     = w_match;
        w_flush   = 1'b0;
        arrived_d = 1'b0;
        cmd_err_d = 1'b0;

        if (cmd_rdy) begin
            case (w_op)
                OP_STOP: begin
                    w_flush = 1'b1;
                    w_pop   = 1'b0;
                end
                OP_GO: begin
                    w_flush = 1'b1;
                    w_push  = 1'b1;
                    w_pop   = 1'b0;
                end
                OP_APPEND: begin
                    // A full queue still accepts if the head leaves this cycle
                    if (w_full && !w_pop) cmd_err_d = 1'b1;
                    else                  w_push    = 1'b1;
                end
                default: cmd_err_d = 1'b1;
            endcase
        end

        if (cmd_rdy && w_op == OP_STOP) begin
            state_d = S_IDLE;
        end else if (cmd_rdy && w_op == OP_GO) begin
            state_d = S_MOVE;
        end else if (w_pop) begin
            if (w_count == CW'(1) && !w_push) begin
                state_d   = S_IDLE;
                arrived_d = 1'b1;
            end else begin
`ifdef ROUTE_DWELL_EN
                state_d = S_DWELL;
`else
                state_d = S_MOVE;
`endif
            end
`ifdef ROUTE_DWELL_EN
        end else if (state_q == S_DWELL && dwell_cnt_q == DW'(DWELL_CYC - 1)) begin
            state_d = S_MOVE;
`endif
        end else if (w_push && state_q == S_IDLE) begin
            state_d = S_MOVE;
        end
    end

    // State and registered status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            in_transit_q <= 1'b0;
            arrived_q    <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_transit_q <= (state_d == S_MOVE);
            arrived_q    <= arrived_d;
            cmd_err_q    <= cmd_err_d;
        end
    end

    assign w_buzz_cond = in_transit_q & ~OK2Move;

    // Buzzer square wave while blocked; counter and output clear otherwise
    always_ff @(posedge clk) begin
        if (!rst_n || !w_buzz_cond) begin
            buzz_cnt_q <= '0;
            buzz_q     <= 1'b0;
        end else if (buzz_cnt_q == BW'(BUZZ_HALF - 1)) begin
            buzz_cnt_q <= '0;
            buzz_q     <= ~buzz_q;
        end else begin
            buzz_cnt_q <= buzz_cnt_q + BW'(1);
        end
    end

    assign in_transit = in_transit_q;
    assign go         = in_transit_q & OK2Move;
    assign buzz       = buzz_q;
    assign buzz_n     = ~buzz_q;
    assign arrived    = arrived_q;
    assign cmd_err    = cmd_err_q;
    assign q_cnt      = w_count;

endmodule
`default_nettype wire
